// File: rtl/sprite_ram_loader_if.sv
// sprite_ram_loader_if: control, pixel stream and RAM write port of the sprite loader
interface sprite_ram_loader_if #(
  parameter int ADDR_W  = 10,
  parameter int COLOR_W = 4
) ();
  logic               start;
  logic               fill_en;
  logic [COLOR_W-1:0] fill_color;
  logic               in_valid;
  logic [COLOR_W-1:0] in_data;
  logic               in_ready;
  logic               we;
  logic [ADDR_W-1:0]  write_address;
  logic [COLOR_W-1:0] data_In;
  logic [ADDR_W-1:0]  write_x;
  logic [ADDR_W-1:0]  write_y;
  logic               busy;
  logic               done;
  modport master (
    output start, fill_en, fill_color, in_valid, in_data,
    input  in_ready, we, write_address, data_In, write_x, write_y, busy, done
  );
  modport slave (
    input  start, fill_en, fill_color, in_valid, in_data,
    output in_ready, we, write_address, data_In, write_x, write_y, busy, done
  );
endinterface

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: writes one sprite image into RAM from a pixel stream or a constant fill colour
module sprite_ram_loader #(
  parameter int SPRITE_W  = 20,
  parameter int SPRITE_H  = 20,
  parameter int ADDR_W    = 10,
  parameter int COLOR_W   = 4,
  parameter int BASE_ADDR = 0
) (
  input logic Clk,
  input logic Reset,
  sprite_ram_loader_if.slave bus
);
  localparam int N = SPRITE_W * SPRITE_H;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(SPRITE_W - 1);
  if (BASE_ADDR + N > (1 << ADDR_W)) begin : g_range
    $error("sprite image does not fit in the RAM address space");
  end
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] count, col, row;
  logic [COLOR_W-1:0] color;
  logic wr;
  // state register
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : state_nx;
  // next state, handshake and status; wr marks a pixel write this cycle
  always_comb begin
    bus.in_ready = state == LOAD;
    bus.busy     = state != IDLE;
    bus.done     = state == DONE;
    wr           = (state == LOAD && bus.in_valid) || state == FILL;
    state_nx     = state == IDLE ? (bus.start ? (bus.fill_en ? FILL : LOAD) : IDLE)
                 : state == DONE ? IDLE
                 : (wr && count == LAST) ? DONE : state;
  end
  // counters and registered RAM write port; address/data hold while idle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count             <= '0;
      col               <= '0;
      row               <= '0;
      color             <= '0;
      bus.we            <= 1'b0;
      bus.write_address <= '0;
      bus.data_In       <= '0;
      bus.write_x       <= '0;
      bus.write_y       <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        count <= '0;
        col   <= '0;
        row   <= '0;
        color <= bus.fill_color;
      end else if (wr) begin
        count <= count + 1'b1;
        col   <= col == COL_LAST ? '0 : col + 1'b1;
        row   <= col == COL_LAST ? row + 1'b1 : row;
      end
      bus.we <= wr;
      if (wr) begin
        bus.write_address <= BASE + count;
        bus.data_In       <= state == FILL ? color : bus.in_data;
        bus.write_x       <= col;
        bus.write_y       <= row;
      end
    end
  end
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: directed checks of LOAD, FILL, backpressure, reset and an offset 8x8 instance
module tb_sprite_ram_loader;
  logic Clk = 1'b0;
  logic Reset;
  int n_checks = 0;
  int n_fail = 0;
  always #5 Clk = ~Clk;
  sprite_ram_loader_if #(.ADDR_W(10), .COLOR_W(4)) a ();
  sprite_ram_loader_if #(.ADDR_W(10), .COLOR_W(4)) b ();
  sprite_ram_loader dut_a (.Clk(Clk), .Reset(Reset), .bus(a));
  sprite_ram_loader #(.SPRITE_W(8), .SPRITE_H(8), .BASE_ADDR(400)) dut_b (.Clk(Clk), .Reset(Reset), .bus(b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic run_load(input bit rnd, input int limit, input bit poke);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit acc;
    a.fill_en = 1'b0;
    a.in_valid = 1'b0;
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    check("ld_ready_first", a.in_ready, 1);
    check("ld_we_first", a.we, 0);
    while (got < limit && cyc < 5000) begin
      a.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a.in_data = 4'(sent);
      a.start = poke && cyc == 50;
      a.fill_en = poke && cyc == 50;
      acc = a.in_valid;
      step();
      cyc++;
      a.start = 1'b0;
      a.fill_en = 1'b0;
      if (acc) sent++;
      check("ld_we", a.we, 32'(acc));
      check("ld_done", a.done, 32'(acc && sent == 400));
      check("ld_busy", a.busy, 1);
      check("ld_ready", a.in_ready, 32'(sent < 400));
      if (a.we) begin
        check("ld_addr", a.write_address, got);
        check("ld_data", a.data_In, got % 16);
        check("ld_x", a.write_x, got % 20);
        check("ld_y", a.write_y, got / 20);
        got++;
      end
    end
    check("ld_count", got, limit);
  endtask
  initial begin
    a.start = 0; a.fill_en = 0; a.fill_color = 0; a.in_valid = 0; a.in_data = 0;
    b.start = 0; b.fill_en = 0; b.fill_color = 0; b.in_valid = 0; b.in_data = 0;
    Reset = 1'b1;
    a.in_valid = 1'b1;
    step();
    step();
    check("rst_we", a.we, 0);
    check("rst_addr", a.write_address, 0);
    check("rst_data", a.data_In, 0);
    check("rst_x", a.write_x, 0);
    check("rst_y", a.write_y, 0);
    check("rst_ready", a.in_ready, 0);
    check("rst_busy", a.busy, 0);
    check("rst_done", a.done, 0);
    check("rst_b_we", b.we, 0);
    Reset = 1'b0;
    run_load(1'b0, 400, 1'b0);
    a.in_valid = 1'b1;
    step();
    check("ld_end_busy", a.busy, 0);
    check("ld_end_we", a.we, 0);
    check("ld_end_done", a.done, 0);
    check("ld_end_ready", a.in_ready, 0);
    check("ld_hold_addr", a.write_address, 399);
    check("ld_hold_data", a.data_In, 15);
    run_load(1'b1, 400, 1'b0);
    step();
    check("bp_end_busy", a.busy, 0);
    a.fill_en = 1'b1;
    a.fill_color = 4'hA;
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    a.fill_en = 1'b0;
    a.fill_color = 4'h5;
    check("fl_we_first", a.we, 0);
    check("fl_busy", a.busy, 1);
    for (int i = 0; i < 400; i++) begin
      a.in_valid = 1'($urandom_range(0, 1));
      a.in_data = 4'($urandom_range(0, 15));
      step();
      check("fl_we", a.we, 1);
      check("fl_addr", a.write_address, i);
      check("fl_data", a.data_In, 4'hA);
      check("fl_done", a.done, 32'(i == 399));
      check("fl_ready", a.in_ready, 0);
    end
    step();
    check("fl_end_busy", a.busy, 0);
    check("fl_end_we", a.we, 0);
    check("fl_end_done", a.done, 0);
    run_load(1'b0, 137, 1'b1);
    Reset = 1'b1;
    a.in_valid = 1'b1;
    step();
    check("mr_we", a.we, 0);
    check("mr_busy", a.busy, 0);
    check("mr_ready", a.in_ready, 0);
    check("mr_addr", a.write_address, 0);
    Reset = 1'b0;
    run_load(1'b1, 400, 1'b0);
    step();
    check("mr_end_busy", a.busy, 0);
    b.fill_en = 1'b0;
    b.in_valid = 1'b1;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    check("b_we_first", b.we, 0);
    for (int i = 0; i < 64; i++) begin
      b.in_data = 4'(i);
      step();
      check("b_we", b.we, 1);
      check("b_addr", b.write_address, 400 + i);
      check("b_data", b.data_In, i % 16);
      check("b_x", b.write_x, i % 8);
      check("b_y", b.write_y, i / 8);
      check("b_done", b.done, 32'(i == 63));
    end
    step();
    check("b_end_busy", b.busy, 0);
    check("b_end_we", b.we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
